// File: rtl/disp_pkg.sv
// Shared definitions for the display scan writer: FSM encoding and packed-entry layout.
package disp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SNAP  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Entry layout: {valid, code, dp}; valid is the MSB, dp the LSB.
  localparam int DIN_DP_BIT = 0;

  function automatic int entry_w(input int digit_w);
    return digit_w + 2;
  endfunction

  function automatic int valid_bit(input int digit_w);
    return digit_w + 1;
  endfunction

endpackage

// File: rtl/disp_shadow_cmp.sv
// Copy of the last value written to each RAM entry, with a compare against
// a candidate entry so the writer can skip unchanged slots.
module disp_shadow_cmp
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int ENT_W      = entry_w(4),
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [ENT_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] cmp_idx,
  input  logic [ENT_W-1:0]  cmp_data,
  output logic              changed
);

  logic [NUM_DIGITS-1:0][ENT_W-1:0] shadow;
  logic [NUM_DIGITS-1:0]            chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr_en && wr_idx == ADDR_W'(i)) shadow[i] <= wr_data;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_cmp
    assign chg[i] = (shadow[i] != cmp_data);
  end

  assign changed = chg[cmp_idx];

endmodule

// File: rtl/display_scan_writer.sv
// Snapshots the digit bank and streams one packed entry per slot into the
// display RAM, highest address first, honouring the RAM stall handshake.
module display_scan_writer
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_W    = 4,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          diff_mode,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         blank,
  input  logic                          wr_ready,
  output logic                          W,
  output logic [ADDR_W-1:0]             WADD,
  output logic [DIGIT_W+1:0]            DIN,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int              ENT_W = entry_w(DIGIT_W);
  localparam int              GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_DIGITS - 1);

  if (2**ADDR_W < NUM_DIGITS) begin : g_addr_chk
    $error("display_scan_writer: ADDR_W too narrow for NUM_DIGITS");
  end

  logic [1:0]                       state;
  logic [ADDR_W-1:0]                idx, nxt_idx;
  logic [GAP_W-1:0]                 gap_cnt;
  logic                             diff_s, force_full;
  logic                             nxt_diff, nxt_wr, changed, slot_done, xfer;
  logic [ENT_W-1:0]                 nxt_ent;
  logic [NUM_DIGITS-1:0][ENT_W-1:0] live, snap;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_live
    assign live[i] = {~blank[i], digits[i*DIGIT_W +: DIGIT_W], dp[i]};
  end

  // The outputs are registered, so the decision for the next slot is made one
  // cycle ahead; in SNAP that slot's entry comes straight from the inputs.
  always_comb begin
    nxt_idx  = (state == ST_SNAP) ? LAST : idx - 1'b1;
    nxt_ent  = snap[nxt_idx];
    nxt_diff = diff_s;
    if (state == ST_SNAP) begin
      nxt_ent  = live[nxt_idx];
      nxt_diff = diff_mode;
    end
    nxt_wr = !nxt_diff || force_full || changed;
  end

  assign xfer      = (state == ST_WRITE) && W && wr_ready;
  assign slot_done = (state == ST_WRITE) && (!W || wr_ready);

  disp_shadow_cmp #(
    .NUM_DIGITS (NUM_DIGITS),
    .ENT_W      (ENT_W),
    .ADDR_W     (ADDR_W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (xfer),
    .wr_idx   (idx),
    .wr_data  (DIN),
    .cmp_idx  (nxt_idx),
    .cmp_data (nxt_ent),
    .changed  (changed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 snap <= '0;
    else if (state == ST_SNAP)  snap <= live;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      diff_s     <= 1'b0;
      force_full <= 1'b1;
      W          <= 1'b0;
      WADD       <= '0;
      DIN        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_SNAP;
            busy  <= 1'b1;
          end
        end
        ST_SNAP: begin
          state  <= ST_WRITE;
          diff_s <= diff_mode;
          idx    <= nxt_idx;
          W      <= nxt_wr;
          if (nxt_wr) begin
            WADD <= nxt_idx;
            DIN  <= nxt_ent;
          end
        end
        ST_WRITE: begin
          if (slot_done) begin
            if (idx == '0) begin
              W          <= 1'b0;
              frame_done <= 1'b1;
              force_full <= 1'b0;
              if (GAP_CYCLES > 0) begin
                state   <= ST_GAP;
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
              end else if (enable) begin
                state <= ST_SNAP;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              idx <= nxt_idx;
              W   <= nxt_wr;
              // skip slots leave address/data parked on the last write
              if (nxt_wr) begin
                WADD <= nxt_idx;
                DIN  <= nxt_ent;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            if (enable) begin
              state <= ST_SNAP;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          W     <= 1'b0;
        end
      endcase
    end
  end

endmodule
